fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 77 +++++++
 tb/tb_fetch_queue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode pipeline definitions: default word widths and the
// fetch-word record passed between the fetch, queue and decode stages.
package fetch_queue_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_word_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int W     = WORD_W + ADDR_W,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // No reset: contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction FIFO with early back-pressure (one slot held
// back for the word already in flight) and single-cycle branch flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int WORD  = WORD_W,
    parameter int ADDR  = ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     v_i,
    input  logic [WORD-1:0]          inst_i,
    input  logic [ADDR-1:0]          pc_i,
    output logic                     stall_o,
    input  logic                     flush,
    output logic                     v_o,
    output logic [WORD-1:0]          inst_o,
    output logic [ADDR-1:0]          pc_o,
    input  logic                     stall_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] FULL     = (CW+1)'(DEPTH);
    localparam logic [CW:0] STALL_AT = (CW+1)'(DEPTH - 1);

    logic [CW-1:0]        rd, wr;
    logic [CW:0]          count;
    logic                 ovf;
    logic                 push, pop;
    logic [WORD+ADDR-1:0] rdata;

    assign pop  = v_o & ~stall_i;
    assign push = v_i & ((count < FULL) | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop)  rd <= rd + 1'b1;
            count <= count + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
            // Word arriving at a full, non-draining queue is dropped.
            if (v_i && count == FULL && !pop) ovf <= 1'b1;
        end
    end

    fetch_queue_mem #(
        .W     (WORD + ADDR),
        .DEPTH (DEPTH),
        .AW    (CW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush & reset),
        .waddr (wr),
        .wdata ({inst_i, pc_i}),
        .raddr (rd),
        .rdata (rdata)
    );

    assign v_o     = (count != '0);
    assign inst_o  = v_o ? rdata[WORD+ADDR-1:ADDR] : '0;
    assign pc_o    = v_o ? rdata[ADDR-1:0] : '0;
    assign stall_o = (count >= STALL_AT);
    assign count_o = count;
    assign ovf_o   = ovf;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, v_i, flush, stall_i;
    logic [31:0] inst_i, inst_o;
    logic [15:0] pc_i, pc_o;
    logic        stall_o, v_o, ovf_o;
    logic [2:0]  count_o;

    int tests = 0;
    int fails = 0;

    fetch_word_t m_q[$];
    bit          m_ovf;
    bit          known = 0;

    fetch_queue #(.WORD(32), .ADDR(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
        .stall_o(stall_o), .flush(flush), .v_o(v_o), .inst_o(inst_o),
        .pc_o(pc_o), .stall_i(stall_i), .count_o(count_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("v_o",     64'(v_o),     64'(n != 0));
        chk("inst_o",  64'(inst_o),  n != 0 ? 64'(m_q[0].inst) : 64'd0);
        chk("pc_o",    64'(pc_o),    n != 0 ? 64'(m_q[0].pc) : 64'd0);
        chk("count_o", 64'(count_o), 64'(n));
        chk("stall_o", 64'(stall_o), 64'(n >= DEPTH - 1));
        chk("ovf_o",   64'(ovf_o),   64'(m_ovf));
    endtask

    // One clock: drive at negedge, check registered outputs, advance model.
    task automatic step(input bit rst_n, input bit v, input logic [31:0] inst,
                        input logic [15:0] pc, input bit stl, input bit fl);
        bit p, q;
        fetch_word_t w;
        reset = rst_n; v_i = v; inst_i = inst; pc_i = pc; stall_i = stl; flush = fl;
        if (known) check_model();
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 0;
            known = 1;
        end else if (fl) begin
            m_q.delete();
        end else begin
            p = (m_q.size() != 0) && !stl;
            q = v && (m_q.size() < DEPTH || p);
            if (v && m_q.size() == DEPTH && !p) m_ovf = 1;
            if (p) void'(m_q.pop_front());
            w.inst = inst;
            w.pc   = pc;
            if (q) m_q.push_back(w);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; v_i = 0; inst_i = '0; pc_i = '0; stall_i = 0; flush = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hdead, 16'h5, 0, 1);
        chk("rst_v_o", 64'(v_o), 0);
        chk("rst_count", 64'(count_o), 0);
        chk("rst_stall", 64'(stall_o), 0);
        chk("rst_ovf", 64'(ovf_o), 0);

        // Streaming with no stall: occupancy stays at most 1.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h11 + 32'(i), 16'(i), 0, 0);
            chk("stream_pc", 64'(pc_o), 64'(i));
            chk("stream_cnt", 64'(count_o), 1);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("stream_empty", 64'(v_o), 0);

        // Back-pressure: stall_o at 3, in-flight word accepted to reach 4.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h100 + 32'(i), 16'(i), 1, 0);
        chk("bp_count", 64'(count_o), 4);
        chk("bp_stall", 64'(stall_o), 1);
        chk("bp_ovf", 64'(ovf_o), 0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_pc", 64'(pc_o), 64'(i));
            step(1, 0, 0, 0, 0, 0);
        end
        chk("bp_drained", 64'(count_o), 0);

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h200 + 32'(i), 16'(16 + i), 1, 0);
        step(1, 1, 32'h2ff, 16'h2ff, 0, 0);
        chk("full_pp_cnt", 64'(count_o), 4);
        chk("full_pp_head", 64'(pc_o), 17);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);

        // Flush mid-stream discards held and incoming entries.
        for (int i = 0; i < 3; i++) step(1, 1, 32'h300 + 32'(i), 16'(32 + i), 1, 0);
        chk("pre_flush_cnt", 64'(count_o), 3);
        step(1, 1, 32'h340, 16'h0040, 0, 1);
        chk("flush_v", 64'(v_o), 0);
        chk("flush_stall", 64'(stall_o), 0);
        step(1, 1, 32'h380, 16'h0080, 0, 0);
        chk("flush_next_pc", 64'(pc_o), 16'h0080);
        step(1, 0, 0, 0, 0, 0);

        // Overflow: sticky, contents preserved, survives flush, cleared by reset.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h400 + 32'(i), 16'(48 + i), 1, 0);
        step(1, 1, 32'h4ff, 16'h4ff, 1, 0);
        chk("ovf_set", 64'(ovf_o), 1);
        chk("ovf_head", 64'(pc_o), 48);
        chk("ovf_cnt", 64'(count_o), 4);
        step(1, 0, 0, 0, 1, 0);
        chk("ovf_sticky", 64'(ovf_o), 1);
        step(1, 0, 0, 0, 0, 1);
        chk("ovf_after_flush", 64'(ovf_o), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("ovf_reset", 64'(ovf_o), 0);

        // Random traffic with a protocol-correct producer exercising wrap.
        for (int i = 0; i < 80; i++) begin
            bit v;
            v = !stall_o && ($urandom_range(0, 3) != 0);
            step(1, v, $urandom, 16'(i + 256), $urandom_range(0, 2) == 0, 0);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        chk("final_empty", 64'(count_o), 0);
        chk("final_ovf", 64'(ovf_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
